spi_key_rx_fifo: RTL and testbench

SPI_KEY_RX_FIFO -- requirements
Module: spi_key_rx_fifo

---
 rtl/spi_key_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_spi_key_rx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_key_rx_fifo.sv
// SPI slave receiver for keyboard words: synchronises the SPI pins into clk,
// assembles MSB-first words and queues them in a first-word-fall-through FIFO.
module spi_key_rx_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC        = 2,
  parameter int SAMPLE_FALL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_sck,
  input  logic                     key_mosi,
  input  logic                     key_cs_n,
  output logic [WIDTH-1:0]         key_out,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC-1:0] sck_sync, mosi_sync, cs_sync;
  logic            sck_d, cs_d;
  logic            sck_s, mosi_s, cs_s;
  logic            sck_edge, cs_fall, cs_rise;
  logic [2:0]      settle_cnt;
  logic            settle_done;
  logic [BW-1:0]   bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic            push_pend;
  logic            enter_shift, shift_en, frame_abort, word_done;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, pop, wr, ovf_set;

  // Synchronisers; cs_n stages reset high so reset itself never looks like a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC-2:0], key_sck};
      mosi_sync <= {mosi_sync[SYNC-2:0], key_mosi};
      cs_sync   <= {cs_sync[SYNC-2:0], key_cs_n};
      sck_d     <= sck_sync[SYNC-1];
      cs_d      <= cs_sync[SYNC-1];
    end
  end

  assign sck_s    = sck_sync[SYNC-1];
  assign mosi_s   = mosi_sync[SYNC-1];
  assign cs_s     = cs_sync[SYNC-1];
  assign sck_edge = (SAMPLE_FALL != 0) ? (~sck_s & sck_d) : (sck_s & ~sck_d);
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // The reset value of the cs_n chain is not a real observation, so WAIT_IDLE
  // holds until the chain has refilled from the pin before trusting cs_n high.
  assign settle_done = (settle_cnt == 3'(SYNC + 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_IDLE;
      settle_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == WAIT_IDLE && !settle_done) settle_cnt <= settle_cnt + 3'd1;
    end
  end

  always_comb begin
    state_next  = state;
    enter_shift = 1'b0;
    shift_en    = 1'b0;
    frame_abort = 1'b0;
    case (state)
      WAIT_IDLE: if (settle_done && cs_s) state_next = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_next  = SHIFT;
          enter_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next  = IDLE;
          frame_abort = (bit_cnt != '0);
        end else if (sck_edge) begin
          shift_en = 1'b1;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  assign word_done = shift_en && (bit_cnt == BW'(WIDTH - 1));

  // shreg holds the completed word for the push cycle; the next sck edge is
  // several clk cycles away, so no separate word register is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= word_done;
      if (enter_shift) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        shreg   <= {shreg[WIDTH-2:0], mosi_s};
        bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
      end
    end
  end

  // Read side: rd_valid means rd_data holds the head; a pop happens on any
  // cycle where rd_en=1 and rd_valid=1, rd_en is ignored while empty.
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = rd_en && (count != '0);
  assign wr       = push_pend && (!full || pop);
  assign ovf_set  = push_pend && full && !pop;
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_out   <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_pend) key_out <= shreg;
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      count <= count + (AW+1)'(1);
      else if (!wr && pop) count <= count - (AW+1)'(1);
      overflow  <= ovf_set     | (overflow  & ~clr_flags);
      frame_err <= frame_abort | (frame_err & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_spi_key_rx_fifo.sv
// Directed bench for spi_key_rx_fifo: a rising-edge-sampling instance checked
// throughout, plus a falling-edge-sampling instance on the same pins.
module tb_spi_key_rx_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_sck = 1'b0;
  logic key_mosi = 1'b0;
  logic key_cs_n = 1'b1;
  logic rd_en = 1'b0;
  logic clr_flags = 1'b0;

  logic [WIDTH-1:0] key_out, rd_data;
  logic             rd_valid, overflow, frame_err;
  logic [2:0]       count;
  logic [WIDTH-1:0] key_out_f, rd_data_f;
  logic             rd_valid_f, overflow_f, frame_err_f;
  logic [2:0]       count_f;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  spi_key_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(2), .SAMPLE_FALL(0)) dut (
    .clk(clk), .rst(rst), .key_sck(key_sck), .key_mosi(key_mosi), .key_cs_n(key_cs_n),
    .key_out(key_out), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .overflow(overflow), .frame_err(frame_err), .clr_flags(clr_flags)
  );

  spi_key_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(2), .SAMPLE_FALL(1)) dut_f (
    .clk(clk), .rst(rst), .key_sck(key_sck), .key_mosi(key_mosi), .key_cs_n(key_cs_n),
    .key_out(key_out_f), .rd_en(rd_en), .rd_data(rd_data_f), .rd_valid(rd_valid_f),
    .count(count_f), .overflow(overflow_f), .frame_err(frame_err_f), .clr_flags(clr_flags)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      key_mosi = data[i];
      #120 key_sck = 1'b1;
      #120 key_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] data, input int nbits);
    @(negedge clk);
    key_cs_n = 1'b0;
    #120;
    send_bits(data, nbits);
    #120 key_cs_n = 1'b1;
    #240;
  endtask

  // 16-bit frame with rd_en pulsed in the cycle the rising-edge instance pushes:
  // edge seen after 2 sync flops, push strobe one cycle later, write on the next edge.
  task automatic frame_with_pop(input logic [15:0] data);
    @(negedge clk);
    key_cs_n = 1'b0;
    #120;
    send_bits({16'h0, data[15:1], 1'b0} >> 1, 15);
    key_mosi = data[0];
    #120 key_sck = 1'b1;
    #60  rd_en = 1'b1;
    #20  rd_en = 1'b0;
    #40  key_sck = 1'b0;
    #120 key_cs_n = 1'b1;
    #240;
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (key_out !== 16'h0000) begin errors++; $display("FAIL reset_key_out: got %h expected 0000", key_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_basic();
    frame(32'hFFFF, 16);
    checks++; if (key_out !== 16'hFFFF) begin errors++; $display("FAIL basic_key_out1: got %h expected ffff", key_out); end
    frame(32'h0000, 16);
    checks++; if (key_out !== 16'h0000) begin errors++; $display("FAIL basic_key_out2: got %h expected 0000", key_out); end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", count); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL basic_pop1: got %h expected ffff", rd_data); end
    pop();
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL basic_pop2: got %h expected 0000", rd_data); end
    pop();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", rd_valid); end
    pop();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_pop_empty_count: got %0d expected 0", count); end
  endtask

  task automatic test_frame_err();
    @(negedge clk);
    key_cs_n = 1'b0;
    #120;
    send_bits(32'h15, 5);
    #120 key_cs_n = 1'b1;
    #240;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
    checks++; if (key_out !== 16'h0000) begin errors++; $display("FAIL ferr_key_out: got %h expected 0000", key_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ferr_count: got %0d expected 0", count); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_w;
    for (int i = 1; i <= 5; i++) frame(32'(i), 16);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (key_out !== 16'h0005) begin errors++; $display("FAIL ovf_key_out: got %h expected 0005", key_out); end
    for (int i = 1; i <= 4; i++) begin
      exp_w = 16'(i);
      checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL ovf_pop%0d: got %h expected %h", i, rd_data, exp_w); end
      pop();
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", rd_valid); end
    pulse_clr();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_stream();
    frame(32'hABCD1234, 32);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL stream_count: got %0d expected 2", count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL stream_frame_err: got %b expected 0", frame_err); end
    checks++; if (key_out !== 16'h1234) begin errors++; $display("FAIL stream_key_out: got %h expected 1234", key_out); end
    checks++; if (rd_data !== 16'hABCD) begin errors++; $display("FAIL stream_pop1: got %h expected abcd", rd_data); end
    pop();
    checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL stream_pop2: got %h expected 1234", rd_data); end
    pop();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key_cs_n = 1'b0;
    #120;
    send_bits(32'hA5, 8);
    do_reset();
    send_bits(32'h5A, 8);
    #120 key_cs_n = 1'b1;
    #240;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_frame_err: got %b expected 0", frame_err); end
    checks++; if (key_out !== 16'h0000) begin errors++; $display("FAIL rstmid_key_out: got %h expected 0000", key_out); end
    frame(32'h00C3, 16);
    checks++; if (key_out !== 16'h00C3) begin errors++; $display("FAIL rstmid_after: got %h expected 00c3", key_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rstmid_after_count: got %0d expected 1", count); end
    pop();
  endtask

  task automatic test_full_pop();
    logic [15:0] exp_w;
    for (int i = 0; i < 4; i++) frame(32'h10 + 32'(i), 16);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got %0d expected 4", count); end
    frame_with_pop(16'h0014);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
    checks++; if (key_out !== 16'h0014) begin errors++; $display("FAIL fullpop_key_out: got %h expected 0014", key_out); end
    for (int i = 1; i <= 4; i++) begin
      exp_w = 16'h0010 + 16'(i);
      checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL fullpop_pop%0d: got %h expected %h", i, rd_data, exp_w); end
      pop();
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained: got %b expected 0", rd_valid); end
  endtask

  task automatic test_sample_fall();
    do_reset();
    frame(32'hFFFF, 16);
    checks++; if (key_out_f !== 16'hFFFF) begin errors++; $display("FAIL fall_key_out1: got %h expected ffff", key_out_f); end
    frame(32'h0000, 16);
    checks++; if (key_out_f !== 16'h0000) begin errors++; $display("FAIL fall_key_out2: got %h expected 0000", key_out_f); end
    checks++; if (count_f !== 3'd2) begin errors++; $display("FAIL fall_count: got %0d expected 2", count_f); end
    checks++; if (frame_err_f !== 1'b0) begin errors++; $display("FAIL fall_frame_err: got %b expected 0", frame_err_f); end
    checks++; if (rd_data_f !== 16'hFFFF) begin errors++; $display("FAIL fall_pop1: got %h expected ffff", rd_data_f); end
    pop();
    checks++; if (rd_data_f !== 16'h0000) begin errors++; $display("FAIL fall_pop2: got %h expected 0000", rd_data_f); end
    pop();
    checks++; if (rd_valid_f !== 1'b0) begin errors++; $display("FAIL fall_empty: got %b expected 0", rd_valid_f); end
    checks++; if (overflow_f !== 1'b0) begin errors++; $display("FAIL fall_overflow: got %b expected 0", overflow_f); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_overflow();
    test_stream();
    test_reset_mid();
    test_full_pop();
    test_sample_fall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
